// File: rtl/eth_gen_pkg.sv
// Shared definitions for the Ethernet test-frame generator.
//   - frame length limits and header byte offsets
//   - generator FSM state type
//   - helpers: length clamp, beat count, and content byte lookup
package eth_gen_pkg;

  localparam int MIN_LEN  = 60;
  localparam int MAX_LEN  = 1514;

  localparam int DST_OFF  = 0;
  localparam int SRC_OFF  = 6;
  localparam int TYPE_OFF = 12;
  localparam int SEQ_OFF  = 14;
  localparam int PAY_OFF  = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } gen_state_t;

  // Force the requested length into the legal frame range.
  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    if (len < 11'(MIN_LEN)) begin
      return 11'(MIN_LEN);
    end
    if (len > 11'(MAX_LEN)) begin
      return 11'(MAX_LEN);
    end
    return len;
  endfunction

  // Number of 8-byte beats needed for a (clamped) frame length.
  function automatic logic [7:0] beats_for(input logic [10:0] len);
    return 8'(({1'b0, len} + 12'd7) >> 3);
  endfunction

  // Content byte at frame index i. Multi-byte header fields go out
  // most-significant byte first; the payload is the low byte of the index.
  function automatic logic [7:0] byte_at(
    input logic [10:0] i,
    input logic [31:0] seq,
    input logic [47:0] dst,
    input logic [47:0] src,
    input logic [15:0] etype
  );
    int k;
    k = int'(i);
    if (k < SRC_OFF) begin
      return dst[8*(SRC_OFF - 1 - (k - DST_OFF)) +: 8];
    end
    if (k < TYPE_OFF) begin
      return src[8*(TYPE_OFF - 1 - k) +: 8];
    end
    if (k < SEQ_OFF) begin
      return etype[8*(SEQ_OFF - 1 - k) +: 8];
    end
    if (k < PAY_OFF) begin
      return seq[8*(PAY_OFF - 1 - k) +: 8];
    end
    return i[7:0];
  endfunction

endpackage

// File: rtl/eth_beat_fmt.sv
// Combinational beat formatter: builds one 64-bit AXI-Stream beat of a
// test frame.
// Ports:
//   beat  in  8   beat index within the frame
//   len   in  11  frame length in bytes (already clamped)
//   seq   in  32  sequence number carried in the header
//   tdata out 64  beat data, byte 0 in [7:0], bytes past len are 0
//   tkeep out 8   byte enables for the beat
module eth_beat_fmt
  import eth_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC   = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic [7:0]  beat,
  input  logic [10:0] len,
  input  logic [31:0] seq,
  output logic [63:0] tdata,
  output logic [7:0]  tkeep
);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [10:0] idx;
      logic        lane_on;

      assign idx     = {beat, 3'(gi)};
      assign lane_on = (idx < len);

      assign tkeep[gi]         = lane_on;
      assign tdata[8*gi +: 8]  = lane_on ? byte_at(idx, seq, DST_MAC, SRC_MAC, ETHERTYPE)
                                         : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/eth_test_frame_gen.sv
// Ethernet test-frame generator: streams numbered test frames on a 64-bit
// AXI4-Stream master, separated by a fixed idle gap.
// Ports:
//   clk_156        in  1   clock
//   sys_rst        in  1   synchronous active-high reset
//   enable         in  1   generate frames while high
//   cfg_len        in  11  frame length (bytes, no FCS), sampled at frame start
//   m_axis_tdata   out 64  stream data
//   m_axis_tkeep   out 8   byte enables
//   m_axis_tvalid  out 1   stream valid
//   m_axis_tlast   out 1   last beat of frame
//   m_axis_tready  in  1   downstream ready
//   busy           out 1   high while sending or in the inter-frame gap
//   frame_count    out 32  frames whose last beat was accepted
module eth_test_frame_gen
  import eth_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC    = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int          IFG_CYCLES = 3
) (
  input  logic        clk_156,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [10:0] cfg_len,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        busy,
  output logic [31:0] frame_count
);

  localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);
  localparam logic        NO_GAP   = (IFG_CYCLES == 0);

  gen_state_t  state_reg, state_next;
  logic [10:0] len_reg, len_next;
  logic [7:0]  beat_reg, beat_next;
  logic [31:0] seq_reg, seq_next;
  logic [31:0] fc_reg, fc_next;
  logic [15:0] gap_reg, gap_next;
  logic [63:0] tdata_reg, tdata_next;
  logic [7:0]  tkeep_reg, tkeep_next;
  logic        tvalid_reg, tvalid_next;
  logic        tlast_reg, tlast_next;
  logic        busy_reg, busy_next;

  logic        handshake;
  logic        last_hs;
  logic        start_idle;
  logic        restart;
  logic        start_frame;
  logic [7:0]  fmt_beat;
  logic [10:0] fmt_len;
  logic [31:0] fmt_seq;
  logic [63:0] fmt_tdata;
  logic [7:0]  fmt_tkeep;
  logic        fmt_last;
  logic        load;

  assign handshake = tvalid_reg & m_axis_tready;
  assign last_hs   = handshake & tlast_reg;

  // Without a gap the next frame starts straight from the tlast handshake;
  // its sequence number is the post-increment value.
  assign start_idle  = (state_reg == IDLE) & enable;
  assign restart     = NO_GAP & (state_reg == SEND) & last_hs & enable;
  assign start_frame = start_idle | restart;

  // The formatter is always pointed at the beat that will be presented next,
  // so its result can be captured straight into the output registers.
  assign fmt_beat = start_frame ? 8'd0 : 8'(beat_reg + 8'd1);
  assign fmt_len  = start_frame ? clamp_len(cfg_len) : len_reg;
  assign fmt_seq  = restart ? 32'(seq_reg + 32'd1) : seq_reg;
  assign fmt_last = (fmt_beat == 8'(beats_for(fmt_len) - 8'd1));

  eth_beat_fmt #(
    .DST_MAC   (DST_MAC),
    .SRC_MAC   (SRC_MAC),
    .ETHERTYPE (ETHERTYPE)
  ) u_fmt (
    .beat  (fmt_beat),
    .len   (fmt_len),
    .seq   (fmt_seq),
    .tdata (fmt_tdata),
    .tkeep (fmt_tkeep)
  );

  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    beat_next   = beat_reg;
    seq_next    = seq_reg;
    fc_next     = fc_reg;
    gap_next    = gap_reg;
    tdata_next  = tdata_reg;
    tkeep_next  = tkeep_reg;
    tvalid_next = tvalid_reg;
    tlast_next  = tlast_reg;
    load        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = SEND;
          load       = 1'b1;
        end
      end

      SEND: begin
        // While stalled (tvalid & !tready) everything holds.
        if (handshake) begin
          if (tlast_reg) begin
            seq_next = seq_reg + 32'd1;
            fc_next  = fc_reg + 32'd1;
            if (restart) begin
              load = 1'b1;
            end else begin
              tvalid_next = 1'b0;
              tlast_next  = 1'b0;
              tdata_next  = 64'd0;
              tkeep_next  = 8'd0;
              gap_next    = 16'd0;
              state_next  = NO_GAP ? IDLE : GAP;
            end
          end else begin
            load = 1'b1;
          end
        end
      end

      GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_reg + 16'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (load) begin
      len_next    = fmt_len;
      beat_next   = fmt_beat;
      tdata_next  = fmt_tdata;
      tkeep_next  = fmt_tkeep;
      tvalid_next = 1'b1;
      tlast_next  = fmt_last;
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_156) begin
    if (sys_rst) begin
      state_reg  <= IDLE;
      len_reg    <= 11'd0;
      beat_reg   <= 8'd0;
      seq_reg    <= 32'd0;
      fc_reg     <= 32'd0;
      gap_reg    <= 16'd0;
      tdata_reg  <= 64'd0;
      tkeep_reg  <= 8'd0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      len_reg    <= len_next;
      beat_reg   <= beat_next;
      seq_reg    <= seq_next;
      fc_reg     <= fc_next;
      gap_reg    <= gap_next;
      tdata_reg  <= tdata_next;
      tkeep_reg  <= tkeep_next;
      tvalid_reg <= tvalid_next;
      tlast_reg  <= tlast_next;
      busy_reg   <= busy_next;
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tkeep  = tkeep_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign busy          = busy_reg;
  assign frame_count   = fc_reg;

endmodule
